// File: rtl/y86_pkg.sv
// Y86-64 encodings shared by the execute stage and its helpers.
// No logic, constants only.
// Not applicable (no handshake).
package y86_pkg;

  // icode values
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVQ  = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // OPq function codes
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // cmovXX / jXX condition codes
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // bit positions inside the {ZF,SF,OF} register
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // value the condition-code register takes out of reset
  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/execute_pipe_if.sv
// Handshake and data bundle between decode, execute and memory stages.
// No latency of its own; signals are plain wires.
// in_valid/in_ready upstream, out_valid/out_ready downstream.
interface execute_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_icode;
  logic [3:0]       in_ifun;
  logic [WIDTH-1:0] in_valA;
  logic [WIDTH-1:0] in_valB;
  logic [WIDTH-1:0] in_valC;
  logic [TAG_W-1:0] in_tag;
  logic             set_cc;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_icode;
  logic [WIDTH-1:0] out_valE;
  logic             out_cnd;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       cc;

  // environment side: drives instructions, consumes results
  modport master (
    output in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, in_tag,
    output set_cc, out_ready,
    input  in_ready, out_valid, out_icode, out_valE, out_cnd, out_err,
    input  out_tag, cc
  );

  // execute stage side
  modport slave (
    input  in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, in_tag,
    input  set_cc, out_ready,
    output in_ready, out_valid, out_icode, out_valE, out_cnd, out_err,
    output out_tag, cc
  );

endinterface

// File: rtl/cond_eval.sv
// Evaluates a cmovXX/jXX condition against {ZF,SF,OF}.
// Purely combinational, zero latency.
// No handshake; illegal ifun forces cnd=0.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [2:0] cc,
  output logic       cnd,
  output logic       illegal
);

  logic zf, sf, of_;

  assign zf  = cc[CC_ZF];
  assign sf  = cc[CC_SF];
  assign of_ = cc[CC_OF];

  // decode the condition; anything beyond C_G is not a Y86 condition
  always_comb begin
    cnd     = 1'b0;
    illegal = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of_) | zf;
      C_L:     cnd = sf ^ of_;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of_);
      C_G:     cnd = ~(sf ^ of_) & ~zf;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_pipe.sv
// Y86-64 execute stage: computes valE, evaluates cnd, owns the CC register.
// Latency 1: an accepted instruction's result is visible the next cycle.
// One-entry output register; in_ready = !out_valid || out_ready, so full throughput.
module execute_pipe
  import y86_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int STACK_STEP = 8,
  parameter int TAG_W      = 8
) (
  input logic           clk,
  input logic           rst_n,
  execute_pipe_if.slave bus
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);
  localparam int               MSB  = WIDTH - 1;

  // output register and architectural state
  logic             out_valid_q;
  logic [3:0]       out_icode_q;
  logic [WIDTH-1:0] out_valE_q;
  logic             out_cnd_q;
  logic             out_err_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [2:0]       cc_q;

  // next-state values for the instruction currently on the inputs
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] vale_n;
  logic             cnd_n;
  logic             err_n;
  logic             cc_we;
  logic [2:0]       cc_n;
  logic             cond_raw;
  logic             cond_ill;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  cond_eval u_cond_eval (
    .ifun    (bus.in_ifun),
    .cc      (cc_q),
    .cnd     (cond_raw),
    .illegal (cond_ill)
  );

  // per-class valE selection, error detection and the OPq flag computation
  always_comb begin
    vale_n = '0;
    cnd_n  = 1'b0;
    err_n  = 1'b0;
    cc_we  = 1'b0;
    cc_n   = cc_q;
    case (bus.in_icode)
      I_HALT, I_NOP: vale_n = '0;
      I_CMOVQ: begin
        err_n  = cond_ill;
        cnd_n  = cond_raw && !cond_ill;
        vale_n = cond_ill ? '0 : bus.in_valA;
      end
      I_JXX: begin
        err_n = cond_ill;
        cnd_n = cond_raw && !cond_ill;
      end
      I_IRMOVQ:          vale_n = bus.in_valC;
      I_RMMOVQ, I_MRMOVQ: vale_n = bus.in_valB + bus.in_valC;
      I_CALL, I_PUSHQ:   vale_n = bus.in_valB - STEP;
      I_RET, I_POPQ:     vale_n = bus.in_valB + STEP;
      I_OPQ: begin
        case (bus.in_ifun)
          ALU_ADD: vale_n = bus.in_valB + bus.in_valA;
          ALU_SUB: vale_n = bus.in_valB - bus.in_valA;
          ALU_AND: vale_n = bus.in_valB & bus.in_valA;
          ALU_XOR: vale_n = bus.in_valB ^ bus.in_valA;
          default: err_n  = 1'b1;
        endcase
        // flags only follow a legal OPq that downstream has not cancelled
        cc_we        = !err_n && bus.set_cc;
        cc_n[CC_ZF]  = (vale_n == '0);
        cc_n[CC_SF]  = vale_n[MSB];
        cc_n[CC_OF]  = 1'b0;
        if (bus.in_ifun == ALU_ADD)
          cc_n[CC_OF] = (bus.in_valA[MSB] == bus.in_valB[MSB]) &&
                        (vale_n[MSB] != bus.in_valA[MSB]);
        else if (bus.in_ifun == ALU_SUB)
          cc_n[CC_OF] = (bus.in_valB[MSB] != bus.in_valA[MSB]) &&
                        (vale_n[MSB] != bus.in_valB[MSB]);
      end
      default: err_n = 1'b1;
    endcase
  end

  // one-entry result register: load on accept, drain when downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_icode_q <= '0;
      out_valE_q  <= '0;
      out_cnd_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_icode_q <= bus.in_icode;
      out_valE_q  <= vale_n;
      out_cnd_q   <= cnd_n;
      out_err_q   <= err_n;
      out_tag_q   <= bus.in_tag;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // condition codes change only on the edge that accepts a flag-setting OPq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cc_q <= CC_RESET;
    else if (accept && cc_we)
      cc_q <= cc_n;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_icode = out_icode_q;
  assign bus.out_valE  = out_valE_q;
  assign bus.out_cnd   = out_cnd_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.cc        = cc_q;

endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle Y86-64 execute stage.
- Computes valE for every instruction class and evaluates the cmovXX/jXX condition.
- Owns the architectural condition-code register (ZF, SF, OF).
- Adds a valid/ready handshake with a one-entry output register, so it sits between decode and memory stages with back-pressure.

Parameters:
- WIDTH, 64, datapath width of valA/valB/valC/valE (≥8).
- STACK_STEP, 8, byte adjustment applied to the stack pointer for call/ret/pushq/popq.
- TAG_W, 8, width of the opaque sideband tag (dstE/dstM/PC index) carried alongside each instruction.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_icode  in  4  Y86 icode
- in_ifun  in  4  Y86 ifun
- in_valA  in  WIDTH  operand A
- in_valB  in  WIDTH  operand B
- in_valC  in  WIDTH  immediate/displacement
- in_tag  in  TAG_W  sideband, passed through unchanged
- set_cc  in  1  qualifies the CC write for an accepted OPq; 0 suppresses it (downstream exception)
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream accepts the result
- out_icode  out  4  registered icode
- out_valE  out  WIDTH  registered result
- out_cnd  out  1  registered condition outcome
- out_err  out  1  illegal icode/ifun flagged
- out_tag  out  TAG_W  registered sideband
- cc  out  3  current {ZF,SF,OF}

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; out_valE=0; out_cnd=0; out_err=0; out_icode=0; out_tag=0.
  - cc={ZF=1,SF=0,OF=0}.
  - Any in-flight result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept, the output register loads the new result and out_valid=1 the next cycle (latency 1).
  - If out_valid && out_ready && !accept, out_valid→0.
  - Output holds stable while out_valid && !out_ready.
  - Throughput is 1 per cycle.
- valE, all arithmetic modulo 2^WIDTH:
  - cmovXX: valA.
  - irmovq: valC.
  - rmmovq/mrmovq: valB+valC.
  - OPq, ifun 0..3: valB+valA, valB−valA, valB&valA, valB^valA.
  - call/pushq: valB−STACK_STEP.
  - ret/popq: valB+STACK_STEP.
  - jXX, nop, halt: 0.
- cnd, evaluated against cc as it stands before the accepting edge:
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - Only cmovXX/jXX produce a nonzero cnd; all other icodes give cnd=0.
- CC update, on the accepting edge of OPq with legal ifun and set_cc=1:
  - ZF = (valE==0); SF = valE[WIDTH−1].
  - OF add: A,B same sign and E sign differs from them.
  - OF sub: B,A signs differ and E sign differs from B.
  - OF and/xor: 0.
  - The next accepted instruction sees the new cc, so back-to-back OPq→jXX works with no bubble.
- Errors:
  - icode>0xB, OPq ifun>3, or cmov/jXX ifun>6 gives out_err=1, valE=0, cnd=0, and no CC update.
  - The tag still propagates.
- Stall: while the output is stalled, no CC update occurs, since nothing is accepted.
- Reset mid-stall drops the held result; in_ready is 1 after deassertion.

Decomposition:
- y86_pkg:
  - icode localparams (I_HALT..I_POPQ).
  - ALU ifun codes and condition ifun codes.
  - cc bit indices (CC_ZF=2, CC_SF=1, CC_OF=0).
- Sub-module cond_eval:
  - Purely combinational, inputs ifun and cc, output cnd plus illegal flag.
  - Reused later by the pipelined branch-prediction check.

Test Plan:
- Reset, then accept OPq add valA=5, valB=−5 (set_cc=1) → out_valE=0, cc={1,0,0}; a following jXX ifun 3 gives out_cnd=1.
- OPq sub valA=1, valB=0x8000_0000_0000_0000 → valE=0x7FFF_FFFF_FFFF_FFFF, cc={0,0,1}; a following jXX ifun 2 (l) gives cnd=1.
- pushq valB=0x100 → valE=0xF8; popq valB=0xF8 → valE=0x100; cc unchanged; rmmovq valB=0x10, valC=0x8 → 0x18.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable, cc unchanged; release → the queued OPq result appears the next cycle.
- OPq with set_cc=0 → valE correct, cc unchanged; OPq ifun 7 → out_err=1, valE=0, cc unchanged.
- Assert rst_n=0 while out_valid=1 and stalled → out_valid=0 immediately; cc returns to {1,0,0}.
